// File: rtl/sipo_register.sv
// Serial-in parallel-out collector: gathers WORDS serial words into one packed
// record and presents it under a valid/read handshake.
module sipo_register #(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_en,
  input  logic [DATA_WIDTH-1:0]               data_i,
  output logic                                ready_o,
  input  logic                                read_en,
  output logic [WORDS-1:0][DATA_WIDTH-1:0]    data_o,
  output logic                                valid_o,
  output logic [$clog2(WORDS+1)-1:0]          count_o
);

  localparam int CNT_W = $clog2(WORDS+1);
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state;
  logic             wr_acc;
  logic             rd_acc;
  logic [IDX_W-1:0] wr_idx;

  // A full record can be released and refilled in the same cycle, so a read
  // reopens the write port combinationally.
  assign ready_o = !valid_o || read_en;
  assign wr_acc  = write_en && ready_o;
  assign rd_acc  = valid_o && read_en;
  assign wr_idx  = count_o[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      valid_o <= 1'b0;
      count_o <= '0;
      data_o  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (wr_acc) begin
            data_o[wr_idx] <= data_i;
            if (count_o == LAST_CNT) begin
              state   <= FULL;
              valid_o <= 1'b1;
              count_o <= FULL_CNT;
            end else begin
              count_o <= count_o + ONE_CNT;
            end
          end
        end
        FULL: begin
          // Writes only land here when paired with a read; they start the next record.
          if (rd_acc) begin
            state   <= FILL;
            valid_o <= 1'b0;
            if (write_en) begin
              data_o[0] <= data_i;
              count_o   <= ONE_CNT;
            end else begin
              count_o   <= '0;
            end
          end
        end
        default: begin
          state   <= FILL;
          valid_o <= 1'b0;
          count_o <= '0;
        end
      endcase
    end
  end

endmodule
